// File: rtl/n64_vinfo_sequencer.sv
// Video-bus decoder and per-field info extractor for the N64 de-blur parameter bus.
// Optional define VMODE_AUTO_EN: derive PAL/NTSC from line count instead of vmode_man_i.
module n64_vinfo_sequencer #(
  parameter int unsigned color_width_i = 7,
  parameter logic [9:0]  LINE_TH       = 10'd288
) (
  input  logic                     nCLK,
  input  logic                     nRST,
  input  logic                     nDSYNC,
  input  logic [color_width_i-1:0] D_i,
  input  logic                     nForceDeBlur_i,
  input  logic                     nDeBlurMan_i,
  input  logic                     vmode_man_i,
  output logic [6:0]               deblurparams_o,
  output logic                     vinfo_valid_o,
  output logic [9:0]               line_cnt_o
);

  localparam logic [9:0] LineMax = 10'd1023;

  logic [3:0] sync_pre_q, sync_pre_d;
  logic [1:0] data_cnt_q, data_cnt_d;
  logic       blurry_pos_q, blurry_pos_d;
  logic [9:0] line_cnt_q, line_cnt_d;
  logic [9:0] last_cnt_q, last_cnt_d;
  logic [1:0] field_cnt_q, field_cnt_d;
  logic       field_phase_q, field_phase_d;
  logic       n64_480i_q, n64_480i_d;
  logic       vmode_q, vmode_d;
  logic       force_deblur_q, force_deblur_d;
  logic       deblur_man_q, deblur_man_d;

  logic       sync_cycle;
  logic [3:0] sync_nib;
  logic       hsync_fall, vsync_fall;

  assign sync_cycle = ~nDSYNC;
  assign sync_nib   = D_i[3:0];
  // sync_nib = {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
  assign hsync_fall = sync_cycle & sync_pre_q[1] & ~sync_nib[1];
  assign vsync_fall = sync_cycle & sync_pre_q[3] & ~sync_nib[3];

  always_comb begin
    sync_pre_d     = sync_pre_q;
    data_cnt_d     = sync_cycle ? 2'b01 : data_cnt_q + 2'd1;
    blurry_pos_d   = blurry_pos_q;
    line_cnt_d     = line_cnt_q;
    last_cnt_d     = last_cnt_q;
    field_cnt_d    = field_cnt_q;
    field_phase_d  = field_phase_q;
    n64_480i_d     = n64_480i_q;
    vmode_d        = vmode_q;
    force_deblur_d = force_deblur_q;
    deblur_man_d   = deblur_man_q;

    if (sync_cycle) begin
      sync_pre_d   = sync_nib;
      blurry_pos_d = hsync_fall | ~blurry_pos_q;
    end

    if (vsync_fall) begin
      last_cnt_d    = line_cnt_q;
      line_cnt_d    = 10'd0;
`ifdef VMODE_AUTO_EN
      vmode_d       = (line_cnt_q >= LINE_TH);
`else
      vmode_d       = vmode_man_i;
`endif
      field_phase_d = sync_nib[1];
      // No phase reference exists until one field end has been seen
      if (field_cnt_q != 2'd0) begin
        n64_480i_d = (sync_nib[1] != field_phase_q);
      end
      field_cnt_d    = (field_cnt_q == 2'd2) ? 2'd2 : field_cnt_q + 2'd1;
      force_deblur_d = nForceDeBlur_i;
      deblur_man_d   = nDeBlurMan_i;
    end else begin
      if (hsync_fall && (line_cnt_q != LineMax)) begin
        line_cnt_d = line_cnt_q + 10'd1;
      end
      // A saturated line counter means vsync went missing: measurements are stale
      if (line_cnt_q == LineMax) begin
        field_cnt_d = 2'd0;
      end
    end
  end

  always_ff @(negedge nCLK) begin
    if (!nRST) begin
      sync_pre_q     <= 4'hF;
      data_cnt_q     <= 2'b00;
      blurry_pos_q   <= 1'b1;
      line_cnt_q     <= 10'd0;
      last_cnt_q     <= 10'd0;
      field_cnt_q    <= 2'd0;
      field_phase_q  <= 1'b0;
      n64_480i_q     <= 1'b0;
      vmode_q        <= 1'b0;
      force_deblur_q <= 1'b1;
      deblur_man_q   <= 1'b1;
    end else begin
      sync_pre_q     <= sync_pre_d;
      data_cnt_q     <= data_cnt_d;
      blurry_pos_q   <= blurry_pos_d;
      line_cnt_q     <= line_cnt_d;
      last_cnt_q     <= last_cnt_d;
      field_cnt_q    <= field_cnt_d;
      field_phase_q  <= field_phase_d;
      n64_480i_q     <= n64_480i_d;
      vmode_q        <= vmode_d;
      force_deblur_q <= force_deblur_d;
      deblur_man_q   <= deblur_man_d;
    end
  end

  assign deblurparams_o = {data_cnt_q, n64_480i_q, vmode_q, blurry_pos_q,
                           force_deblur_q, deblur_man_q};
  assign vinfo_valid_o  = (field_cnt_q == 2'd2);
  assign line_cnt_o     = last_cnt_q;

  // nCLAMP, nCSYNC and the colour MSBs are carried on the bus but not needed here
  logic unused_sig;
`ifdef VMODE_AUTO_EN
  assign unused_sig = ^{D_i[color_width_i-1:4], sync_pre_q[2], sync_pre_q[0], vmode_man_i};
`else
  assign unused_sig = ^{D_i[color_width_i-1:4], sync_pre_q[2], sync_pre_q[0], LINE_TH};
`endif

endmodule

// File: tb/tb_n64_vinfo_sequencer.sv
// Randomized bench for n64_vinfo_sequencer against an event-level reference model.
module tb_n64_vinfo_sequencer;

  logic       nCLK;
  logic       nRST;
  logic       nDSYNC;
  logic [6:0] D_i;
  logic       nForceDeBlur_i;
  logic       nDeBlurMan_i;
  logic       vmode_man_i;
  logic [6:0] deblurparams_o;
  logic       vinfo_valid_o;
  logic [9:0] line_cnt_o;

  n64_vinfo_sequencer #(
    .color_width_i(7),
    .LINE_TH      (10'd288)
  ) u_dut (
    .nCLK          (nCLK),
    .nRST          (nRST),
    .nDSYNC        (nDSYNC),
    .D_i           (D_i),
    .nForceDeBlur_i(nForceDeBlur_i),
    .nDeBlurMan_i  (nDeBlurMan_i),
    .vmode_man_i   (vmode_man_i),
    .deblurparams_o(deblurparams_o),
    .vinfo_valid_o (vinfo_valid_o),
    .line_cnt_o    (line_cnt_o)
  );

  initial nCLK = 1'b0;
  always #5 nCLK = ~nCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state, in terms of video events rather than registers
  int         m_since_sync;   // cycles since the last sync cycle
  int         m_syncs_since_h; // sync cycles since the last line start
  int         m_lines;        // lines seen in the current field
  int         m_last_lines;
  int         m_fields;       // fields measured, capped at 2
  logic [3:0] m_prev_nib;
  bit         m_vmode, m_480i, m_phase, m_force, m_man;

  function automatic void model_reset();
    m_since_sync    = 0;
    m_syncs_since_h = 0;
    m_lines         = 0;
    m_last_lines    = 0;
    m_fields        = 0;
    m_prev_nib      = 4'hF;
    m_vmode         = 1'b0;
    m_480i          = 1'b0;
    m_phase         = 1'b0;
    m_force         = 1'b1;
    m_man           = 1'b1;
  endfunction

  function automatic void model_step(input logic rst_n, input logic ds_n, input logic [6:0] d);
    bit hf, vf, was_saturated;
    hf = 0;
    vf = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    was_saturated = (m_lines == 1023);
    if (!ds_n) begin
      hf = m_prev_nib[1] && !d[1];
      vf = m_prev_nib[3] && !d[3];
      m_prev_nib   = d[3:0];
      m_since_sync = 1;
      if (hf) m_syncs_since_h = 0;
      else    m_syncs_since_h++;
    end else begin
      m_since_sync++;
    end
    if (vf) begin
      m_last_lines = m_lines;
`ifdef VMODE_AUTO_EN
      m_vmode = (m_lines >= 288);
`else
      m_vmode = vmode_man_i;
`endif
      if (m_fields > 0) m_480i = (d[1] != m_phase);
      m_phase  = d[1];
      m_fields = (m_fields >= 2) ? 2 : m_fields + 1;
      m_lines  = 0;
      m_force  = nForceDeBlur_i;
      m_man    = nDeBlurMan_i;
    end else begin
      if (hf && m_lines < 1023) m_lines++;
      if (was_saturated) m_fields = 0;
    end
  endfunction

  task automatic cyc(input logic ds_n, input logic [3:0] nib);
    logic [6:0] r;
    logic [6:0] exp_params;
    r = 7'($urandom);
    if (!ds_n) r[3:0] = nib;
    nDSYNC = ds_n;
    D_i    = r;
    @(negedge nCLK);
    #1;
    model_step(nRST, ds_n, r);
    exp_params = {2'(m_since_sync % 4), m_480i, m_vmode, (m_syncs_since_h % 2 == 0),
                  m_force, m_man};
    check_eq("params", 32'(deblurparams_o), 32'(exp_params));
    check_eq("valid", 32'(vinfo_valid_o), 32'(m_fields == 2));
    check_eq("line_cnt", 32'(line_cnt_o), 32'(m_last_lines));
  endtask

  task automatic pixel(input logic [3:0] nib);
    cyc(1'b0, nib);
    repeat (3) cyc(1'b1, 4'h0);
  endtask

  task automatic line();
    logic [3:0] rb;
    rb = 4'($urandom);
    pixel({1'b1, rb[2], 1'b0, rb[0]});
    pixel(4'hF);
    // occasional dropped sync: data_cnt must free-run
    if ($urandom_range(0, 15) == 0) repeat ($urandom_range(1, 5)) cyc(1'b1, 4'h0);
  endtask

  task automatic vsync(input logic hs);
    logic [3:0] rb;
    rb = 4'($urandom);
    pixel({1'b0, rb[2], hs, rb[0]});
    pixel(4'hF);
  endtask

  task automatic field(input int n, input logic hs);
    nForceDeBlur_i = 1'($urandom);
    vmode_man_i    = 1'($urandom);
    repeat (n) line();
    vsync(hs);
  endtask

  initial begin
    nRST           = 1'b0;
    nDSYNC         = 1'b1;
    D_i            = '0;
    nForceDeBlur_i = 1'b1;
    nDeBlurMan_i   = 1'b1;
    vmode_man_i    = 1'b0;
    model_reset();

    repeat (3) cyc(1'($urandom), 4'($urandom));
    check_eq("rst_params", 32'(deblurparams_o), 32'(7'b00_0_0_1_1_1));
    check_eq("rst_valid", 32'(vinfo_valid_o), 32'd0);
    nRST = 1'b1;

    repeat (3) pixel(4'hF);
    vsync(1'b1);
    field(263, 1'b1);
    check_eq("ntsc_lines", 32'(line_cnt_o), 32'd263);
    check_eq("ntsc_valid", 32'(vinfo_valid_o), 32'd1);
    check_eq("ntsc_480i", 32'(deblurparams_o[4]), 32'd0);
    field(263, 1'b1);
    check_eq("ntsc_lines2", 32'(line_cnt_o), 32'd263);

    field(313, 1'b1);
    check_eq("pal_lines", 32'(line_cnt_o), 32'd313);
`ifdef VMODE_AUTO_EN
    check_eq("pal_vmode", 32'(deblurparams_o[3]), 32'd1);
`else
    check_eq("man_vmode", 32'(deblurparams_o[3]), 32'(vmode_man_i));
`endif
    field(313, 1'b1);

    field(262, 1'b0);
    check_eq("i480_a", 32'(deblurparams_o[4]), 32'd1);
    field(263, 1'b1);
    field(262, 1'b0);
    field(263, 1'b1);
    check_eq("i480_b", 32'(deblurparams_o[4]), 32'd1);
    check_eq("i480_lines", 32'(line_cnt_o), 32'd263);

    nDeBlurMan_i = 1'b1;
    field(50, 1'b1);
    repeat (20) line();
    nDeBlurMan_i = 1'b0;
    repeat (20) line();
    check_eq("man_hold", 32'(deblurparams_o[0]), 32'd1);
    vsync(1'b1);
    check_eq("man_load", 32'(deblurparams_o[0]), 32'd0);

    repeat (1100) line();
    check_eq("sat_valid", 32'(vinfo_valid_o), 32'd0);
    vsync(1'b1);
    check_eq("sat_lines", 32'(line_cnt_o), 32'd1023);
    field(40, 1'b1);

    repeat (30) line();
    nRST = 1'b0;
    repeat (2) cyc(1'($urandom), 4'($urandom));
    check_eq("mid_rst_params", 32'(deblurparams_o), 32'(7'b00_0_0_1_1_1));
    nRST = 1'b1;
    repeat (10) line();
    vsync(1'b0);
    check_eq("post_rst_480i", 32'(deblurparams_o[4]), 32'd0);
    check_eq("post_rst_valid", 32'(vinfo_valid_o), 32'd0);
    check_eq("post_rst_lines", 32'(line_cnt_o), 32'd10);
    field(40, 1'b1);
    check_eq("post_rst_480i2", 32'(deblurparams_o[4]), 32'd1);
    check_eq("post_rst_valid2", 32'(vinfo_valid_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/n64_vinfo_sequencer.md
# n64_vinfo_sequencer

Sequencer and video-info extractor that drives the parameter bus of the N64 de-blur engine. It decodes the multiplexed N64 video bus (sync nibble followed by R, G and B words) and generates the colour-slot counter and the pixel-pair phase. Once per field it measures line count and field phase to classify PAL/NTSC and 240p/480i. It also latches the user de-blur configuration so that it changes only on frame boundaries.

## Interface
Parameters:
- color_width_i, 7: width of the N64 data bus D_i.
- LINE_TH, 10'd288: lines-per-field threshold. At or above it the field is PAL.

Ports:
- nCLK  input  1  N64 video clock. All logic is clocked on the falling edge.
- nRST  input  1  reset, synchronous, active-low.
- nDSYNC  input  1  low during the sync-nibble cycle of each pixel.
- D_i  input  color_width_i  video data. During the sync cycle, D_i[3:0] = {nVSYNC, nCLAMP, nHSYNC, nCSYNC}.
- nForceDeBlur_i  input  1  user setting: 1 selects estimation-based de-blur, 0 selects the manual setting. Already synchronous to nCLK.
- nDeBlurMan_i  input  1  manual de-blur setting, active-low. Already synchronous to nCLK.
- vmode_man_i  input  1  manual PAL select. Used only when VMODE_AUTO_EN is undefined.
- deblurparams_o  output  7  {data_cnt[1:0], n64_480i, vmode, blurry_pixel_pos, nForceDeBlur, nDeBlurMan}.
- vinfo_valid_o  output  1  high once two consecutive fields have been measured.
- line_cnt_o  output  10  line count of the last complete field.

## Operation
- Sync capture: on every cycle with nDSYNC low, D_i[3:0] is stored in sync_pre (reset value 4'hF).
  - Falling edges of nHSYNC and nVSYNC are detected by comparing sync_pre against D_i[3:0] in the same sync cycle.
- data_cnt:
  - Loads 2'b01 in the cycle after nDSYNC is sampled low; otherwise increments by 1 with wrap.
  - Required sequence: 01 (R), 10 (G), 11 (B), 00 (sync).
  - With a missing sync, data_cnt free-runs modulo 4.
- blurry_pixel_pos: updated only in sync cycles.
  - On an nHSYNC falling edge it loads 1; otherwise it toggles.
- Line counter: 10 bits, incremented on each nHSYNC falling edge, saturating at 1023.
  - Saturation (no nVSYNC seen) clears vinfo_valid_o and the field counter.
- Field end (nVSYNC falling edge):
  - line_cnt_o <= line count.
  - vmode <= (line count >= LINE_TH).
  - field_phase <= D_i[1].
  - n64_480i <= (D_i[1] != previous field_phase).
  - The line counter is cleared to 0.
  - The 2-bit field counter increments, saturating at 2; vinfo_valid_o = (field counter == 2).
  - nForceDeBlur and nDeBlurMan are loaded from the *_i inputs. They hold their value at all other times.
- Simultaneous nVSYNC and nHSYNC falling edges in one sync cycle:
  - vsync handling wins: the counter is cleared to 0, not incremented.
  - blurry_pixel_pos still loads 1.
- n64_480i and vmode are updated only after the first field end since reset. Before that they hold their reset values.

## Timing
- All outputs are registered and are valid one nCLK falling edge after the sync cycle that carried the triggering event.
- data_cnt has one cycle of latency from nDSYNC.
- Reset values:
  - data_cnt 2'b00, n64_480i 0, vmode 0, blurry_pixel_pos 1.
  - nForceDeBlur 1, nDeBlurMan 1.
  - vinfo_valid_o 0, line_cnt_o 0.
  - Field counter 0, field_phase 0.
- Reset asserted mid-field: every register returns to its reset value on the next falling edge. The first post-reset field end performs no 480i comparison (n64_480i stays 0) and sets the field counter to 1.
- Reset has priority over all events in the same cycle.

## Configuration
- VMODE_AUTO_EN defined: vmode comes from the line-count comparison described above.
- VMODE_AUTO_EN undefined: vmode is loaded from vmode_man_i at each field end.
  - LINE_TH is unused in this mode.
  - line_cnt_o and vinfo_valid_o behave unchanged.

## Test plan
- Hold nRST low for 3 cycles with random D_i -> deblurparams_o = 7'b00_0_0_1_1_1, vinfo_valid_o = 0.
- nDSYNC low every 4th cycle -> data_cnt reads 01, 10, 11, 00 in the cycles after each sync; blurry_pixel_pos alternates per pixel and is 1 after each nHSYNC fall.
- Two NTSC 240p fields of 263 lines each, with nHSYNC = 1 at vsync -> after the 2nd field end: line_cnt_o = 263, vmode = 0, n64_480i = 0, vinfo_valid_o = 1.
- Fields of 313 lines -> vmode = 1, line_cnt_o = 313. With VMODE_AUTO_EN undefined and vmode_man_i = 0 -> vmode = 0.
- nHSYNC at vsync alternating 1/0 between fields of 262/263 lines -> n64_480i = 1 from the 2nd field end onward.
- nDeBlurMan_i toggled 1 -> 0 mid-field -> bit 0 stays 1 until the next nVSYNC fall, then reads 0. No vsync for 1100 lines -> vinfo_valid_o drops to 0.
